imem_fetch_ctrl: RTL

- Parametrised instruction memory for the RISC-V core, with a program-load write port and a fetch request/response port.
- Sits between the PC/fetch stage and the program loader.
- Adds over the previous instruction memory: a hardware NOP-fill after reset, registered reads with backpressure, alignment and range fault reporting, and a load-vs-fetch arbiter.

---
 rtl/imem_fetch_ctrl_pkg.sv | 23 ++
 rtl/imem_fetch_ctrl_ram.sv | 34 +++
 rtl/imem_fetch_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction memory fetch controller.
package riscv_imem_pkg;

  // Fill value and fault-response value: addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // INIT runs the hardware NOP-fill; RUN is normal operation
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Returns {misaligned, out_of_range} for a zero-extended byte address.
  // Any address bit above the word index field marks the access out of range.
  function automatic logic [1:0] addr_check(input logic [63:0] addr, input int idx_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (idx_w + 2)) != 64'd0);
    return {misaligned, out_of_range};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_ram.sv
// DEPTH x XLEN instruction storage: one synchronous write port and one
// registered read port with read enable (maps onto a block RAM).
module imem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Write port: one word per cycle when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: output register only updates on an enabled read, so it
  // holds its value while the consumer stalls
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with program-load port, fetch port, NOP-fill after
// reset, registered reads with backpressure and address fault reporting.
module imem_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(riscv_imem_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [XLEN-1:0]   load_data,
  output logic              load_ready,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_instr,
  output logic              rsp_fault,
  input  logic              rsp_ready,
  output logic              busy
);

  import riscv_imem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] init_cnt_reg;
  logic             rsp_valid_reg;
  logic             rsp_fault_reg;
  logic             rsp_from_ram_reg;
  logic             load_err_reg;

  logic [1:0]       load_chk;
  logic [1:0]       fetch_chk;
  logic             load_bad;
  logic             fetch_bad;
  logic             load_fire;
  logic             fetch_fire;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [XLEN-1:0]  ram_wdata;
  logic             ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [XLEN-1:0]  ram_rdata;

  assign load_chk  = addr_check(64'(load_addr), IDX_W);
  assign fetch_chk = addr_check(64'(fetch_addr), IDX_W);
  assign load_bad  = |load_chk;
  assign fetch_bad = |fetch_chk;

  // Loads always win the arbitration; a fetch waits while load_en is high
  assign busy        = (state_reg == INIT);
  assign load_ready  = (state_reg == RUN);
  assign fetch_ready = (state_reg == RUN) && !load_en && (!rsp_valid_reg || rsp_ready);
  assign load_fire   = load_en && load_ready;
  assign fetch_fire  = fetch_req && fetch_ready;

  // Write-port mux: fill counter during INIT, loader during RUN
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = init_cnt_reg;
    ram_wdata = NOP_WORD;
    if (!rst) begin
      if (state_reg == INIT) begin
        ram_we = 1'b1;
      end else if (load_fire && !load_bad) begin
        ram_we    = 1'b1;
        ram_waddr = load_addr[IDX_W+1:2];
        ram_wdata = load_data;
      end
    end
  end

  // Faulting fetches never touch the memory
  assign ram_re    = fetch_fire && !fetch_bad && !rst;
  assign ram_raddr = fetch_addr[IDX_W+1:2];

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // FSM, fill counter, load error pulse and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= INIT;
      init_cnt_reg     <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_fault_reg    <= 1'b0;
      rsp_from_ram_reg <= 1'b0;
      load_err_reg     <= 1'b0;
    end else begin
      load_err_reg <= load_fire && load_bad;

      case (state_reg)
        INIT: begin
          init_cnt_reg <= init_cnt_reg + IDX_W'(1);
          if (init_cnt_reg == LAST_IDX) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg <= INIT;
        end
      endcase

      // A new fetch replaces a consumed response with no bubble; otherwise
      // a consumed response simply retires and a stalled one holds
      if (fetch_fire) begin
        rsp_valid_reg    <= 1'b1;
        rsp_fault_reg    <= fetch_bad;
        rsp_from_ram_reg <= !fetch_bad;
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  // Faults and the post-reset state present the NOP word instead of RAM data
  assign rsp_valid = rsp_valid_reg;
  assign rsp_fault = rsp_fault_reg;
  assign rsp_instr = rsp_from_ram_reg ? ram_rdata : NOP_WORD;
  assign load_err  = load_err_reg;

endmodule
